// File: rtl/four_engine_sched.sv
// four_engine_sched: weight double-buffering and LOAD/COMPUTE/DRAIN sequencing for four conv engines
module four_engine_sched #(
    parameter int NWIN      = 16,
    parameter int DRAIN_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        start,
    input  logic [3:0]  eng_mask,
    input  logic        v_flag,
    input  logic        wr_en,
    input  logic [1:0]  wr_sel,
    input  logic [71:0] wr_data,
    output logic [71:0] wi0,
    output logic [71:0] wi1,
    output logic [71:0] wi2,
    output logic [71:0] wi3,
    output logic [1:0]  ctrl0,
    output logic [1:0]  ctrl1,
    output logic [1:0]  ctrl2,
    output logic [1:0]  ctrl3,
    output logic        busy,
    output logic        done,
    output logic [7:0]  win_cnt,
    output logic        wt_err
);
    typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, COMPUTE = 2'b10, DRAIN = 2'b11} state_t;

    localparam logic [7:0] NW  = 8'(NWIN);
    localparam logic [3:0] DL1 = 4'(DRAIN_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  mask_q, mask_d;
    logic [71:0] shadow_q [4];
    logic [71:0] shadow_d [4];
    logic [71:0] wi_q [4];
    logic [71:0] wi_d [4];
    logic [7:0]  win_cnt_q, win_cnt_d;
    logic [3:0]  dcnt_q, dcnt_d;
    logic        done_q, done_d;
    logic        wt_err_q, wt_err_d;

    function automatic logic has_zero(input logic [71:0] w);
        return w[31:0] == 32'd0 || w[63:32] == 32'd0 || w[71:64] == 8'd0;
    endfunction

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        shadow_d  = shadow_q;
        wi_d      = wi_q;
        win_cnt_d = win_cnt_q;
        dcnt_d    = dcnt_q;
        done_d    = 1'b0;
        wt_err_d  = wt_err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    mask_d  = eng_mask;
                end
            end
            LOAD: begin
                // commit reads shadow_q, so a same-cycle write lands only in the shadow
                for (int i = 0; i < 4; i++) begin
                    if (mask_q[i]) begin
                        wi_d[i] = shadow_q[i];
                        if (has_zero(shadow_q[i])) wt_err_d = 1'b1;
                    end
                end
                win_cnt_d = 8'd0;
                state_d   = COMPUTE;
            end
            COMPUTE: begin
                if (v_flag && win_cnt_q < NW) begin
                    win_cnt_d = win_cnt_q + 8'd1;
                    if (win_cnt_d == NW) begin
                        state_d = DRAIN;
                        dcnt_d  = 4'd0;
                    end
                end
            end
            DRAIN: begin
                dcnt_d = dcnt_q + 4'd1;
                if (dcnt_q == DL1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
        if (wr_en) shadow_d[wr_sel] = wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            mask_q    <= 4'd0;
            win_cnt_q <= 8'd0;
            dcnt_q    <= 4'd0;
            done_q    <= 1'b0;
            wt_err_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= 72'd0;
                wi_q[i]     <= 72'd0;
            end
        end else if (en) begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            win_cnt_q <= win_cnt_d;
            dcnt_q    <= dcnt_d;
            done_q    <= done_d;
            wt_err_q  <= wt_err_d;
            shadow_q  <= shadow_d;
            wi_q      <= wi_d;
        end
    end

    assign wi0     = wi_q[0];
    assign wi1     = wi_q[1];
    assign wi2     = wi_q[2];
    assign wi3     = wi_q[3];
    assign ctrl0   = mask_q[0] ? state_q : IDLE;
    assign ctrl1   = mask_q[1] ? state_q : IDLE;
    assign ctrl2   = mask_q[2] ? state_q : IDLE;
    assign ctrl3   = mask_q[3] ? state_q : IDLE;
    assign busy    = state_q != IDLE;
    assign done    = done_q;
    assign win_cnt = win_cnt_q;
    assign wt_err  = wt_err_q;
endmodule
